// File: rtl/cla_updown_counter_if.sv
// Control/data bundle for cla_updown_counter: the slave side is the counter,
// the master side is whatever drives it.
interface cla_updown_counter_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
);
  logic              en;
  logic              up;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_ovf;
  logic [WIDTH-1:0]  q;
  logic              wrap;
  logic              ovf;

  modport master (output en, up, step, load, load_val, clr_ovf,
                  input  q, wrap, ovf);
  modport slave  (input  en, up, step, load, load_val, clr_ovf,
                  output q, wrap, ovf);
endinterface

// File: rtl/cla_updown_counter.sv
// Up/down counter with programmable step on a two-level carry-lookahead adder:
// 4-bit group cells plus a lookahead layer over the group G/P signals.
module cla_group4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_g,
  output logic       o_p
);
  logic [3:0] w_g, w_p, w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_sum  = w_p ^ w_c;
  // Group G/P are independent of the carry-in so the upper layer never waits on it
  assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_p    = &w_p;
endmodule

module cla_updown_counter #(
  parameter int WIDTH    = 16,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic clock,
  input  logic reset_,
  cla_updown_counter_if.slave bus
);
  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_updown_counter: WIDTH must be a multiple of 4 and >= 4");
  end
  if (STEP_W < 1 || STEP_W > WIDTH) begin : g_bad_step
    $error("cla_updown_counter: STEP_W must be in 1..WIDTH");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap, r_ovf;
  logic [WIDTH-1:0] w_b, w_sum, w_q_nxt;
  logic             w_cin, w_lim, w_wrap_nxt;
  logic [NG-1:0]    w_gg, w_gp;
  logic [NG:0]      w_gc;

  // Subtraction is q + ~step + 1
  assign w_cin = ~bus.up;
  assign w_b   = bus.up ? WIDTH'(bus.step) : ~WIDTH'(bus.step);

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .i_a   (r_q[4*gi +: 4]),
      .i_b   (w_b[4*gi +: 4]),
      .i_cin (w_gc[gi]),
      .o_sum (w_sum[4*gi +: 4]),
      .o_g   (w_gg[gi]),
      .o_p   (w_gp[gi])
    );
  end

  // Each group carry is a flat sum-of-products of G/P terms, not a chain
  always_comb begin
    logic v_acc, v_t;
    w_gc    = '0;
    w_gc[0] = w_cin;
    for (int j = 1; j <= NG; j++) begin
      v_acc = w_cin;
      for (int m = 0; m < j; m++) v_acc = v_acc & w_gp[m];
      for (int k = 0; k < j; k++) begin
        v_t = w_gg[k];
        for (int m = k + 1; m < j; m++) v_t = v_t & w_gp[m];
        v_acc = v_acc | v_t;
      end
      w_gc[j] = v_acc;
    end
  end

  assign w_lim = bus.up ? w_gc[NG] : ~w_gc[NG];

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (bus.load) begin
      w_q_nxt = bus.load_val;
    end else if (bus.en) begin
      w_wrap_nxt = w_lim;
      if (SATURATE != 0 && w_lim) w_q_nxt = bus.up ? {WIDTH{1'b1}} : '0;
      else                        w_q_nxt = w_sum;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
      if (w_wrap_nxt)       r_ovf <= 1'b1;
      else if (bus.clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.q    = r_q;
  assign bus.wrap = r_wrap;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_cla_updown_counter.sv
// Directed bench: 8-bit wrap and saturate counters plus a 16-bit wrap counter
// swept against a simple arithmetic reference.
module tb_cla_updown_counter;
  logic clock = 1'b0;
  logic reset_;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  cla_updown_counter_if #(.WIDTH(8),  .STEP_W(4)) a8w ();
  cla_updown_counter_if #(.WIDTH(8),  .STEP_W(4)) a8s ();
  cla_updown_counter_if #(.WIDTH(16), .STEP_W(4)) a16 ();

  cla_updown_counter #(.WIDTH(8),  .STEP_W(4), .SATURATE(0)) u_w8  (.clock(clock), .reset_(reset_), .bus(a8w));
  cla_updown_counter #(.WIDTH(8),  .STEP_W(4), .SATURATE(1)) u_s8  (.clock(clock), .reset_(reset_), .bus(a8s));
  cla_updown_counter #(.WIDTH(16), .STEP_W(4), .SATURATE(0)) u_w16 (.clock(clock), .reset_(reset_), .bus(a16));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all;
    a8w.en = 0; a8w.up = 1; a8w.step = 0; a8w.load = 0; a8w.load_val = 0; a8w.clr_ovf = 0;
    a8s.en = 0; a8s.up = 1; a8s.step = 0; a8s.load = 0; a8s.load_val = 0; a8s.clr_ovf = 0;
    a16.en = 0; a16.up = 1; a16.step = 0; a16.load = 0; a16.load_val = 0; a16.clr_ovf = 0;
  endtask

  task automatic test_reset;
    idle_all();
    reset_ = 0;
    a8w.en = 1; a8w.up = 1; a8w.step = 4'd5;
    tick();
    checks++;
    if (a8w.q !== 8'h00 || a8w.wrap !== 1'b0 || a8w.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_w8 q=%h wrap=%b ovf=%b exp q=00 wrap=0 ovf=0", a8w.q, a8w.wrap, a8w.ovf);
    end
    checks++;
    if (a8s.q !== 8'h00 || a16.q !== 16'h0000 || a16.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_others s8q=%h w16q=%h w16ovf=%b exp 00/0000/0", a8s.q, a16.q, a16.ovf);
    end
    reset_ = 1;
    tick();
    checks++;
    if (a8w.q !== 8'h05 || a8w.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_release q=%h wrap=%b exp q=05 wrap=0", a8w.q, a8w.wrap);
    end
    a8w.en = 0;
    tick();
  endtask

  task automatic test_wrap_up;
    a8w.load = 1; a8w.load_val = 8'hFD;
    tick();
    checks++;
    if (a8w.q !== 8'hFD || a8w.wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_load q=%h wrap=%b exp q=fd wrap=0", a8w.q, a8w.wrap);
    end
    a8w.load = 0; a8w.en = 1; a8w.up = 1; a8w.step = 4'd4;
    tick();
    checks++;
    if (a8w.q !== 8'h01 || a8w.wrap !== 1'b1 || a8w.ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_cross q=%h wrap=%b ovf=%b exp q=01 wrap=1 ovf=1", a8w.q, a8w.wrap, a8w.ovf);
    end
    a8w.en = 0;
    tick();
    checks++;
    if (a8w.q !== 8'h01 || a8w.wrap !== 1'b0 || a8w.ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pulse_end q=%h wrap=%b ovf=%b exp q=01 wrap=0 ovf=1", a8w.q, a8w.wrap, a8w.ovf);
    end
    a8w.clr_ovf = 1;
    tick();
    a8w.clr_ovf = 0;
    checks++;
    if (a8w.ovf !== 1'b0) begin
      failures++;
      $display("FAIL wrap_clr_ovf ovf=%b exp 0", a8w.ovf);
    end
  endtask

  task automatic test_saturate_up;
    a8s.load = 1; a8s.load_val = 8'hFD;
    tick();
    a8s.load = 0; a8s.en = 1; a8s.up = 1; a8s.step = 4'd4;
    checks++;
    if (a8s.q !== 8'hFD) begin
      failures++;
      $display("FAIL sat_load q=%h exp fd", a8s.q);
    end
    tick();
    checks++;
    if (a8s.q !== 8'hFF || a8s.wrap !== 1'b1 || a8s.ovf !== 1'b1) begin
      failures++;
      $display("FAIL sat_first q=%h wrap=%b ovf=%b exp q=ff wrap=1 ovf=1", a8s.q, a8s.wrap, a8s.ovf);
    end
    tick();
    checks++;
    if (a8s.q !== 8'hFF || a8s.wrap !== 1'b1) begin
      failures++;
      $display("FAIL sat_second q=%h wrap=%b exp q=ff wrap=1", a8s.q, a8s.wrap);
    end
    a8s.en = 0;
    tick();
    checks++;
    if (a8s.q !== 8'hFF || a8s.wrap !== 1'b0 || a8s.ovf !== 1'b1) begin
      failures++;
      $display("FAIL sat_idle q=%h wrap=%b ovf=%b exp q=ff wrap=0 ovf=1", a8s.q, a8s.wrap, a8s.ovf);
    end
  endtask

  task automatic test_down;
    a8w.load = 1; a8w.load_val = 8'h02;
    a8s.load = 1; a8s.load_val = 8'h02;
    tick();
    a8w.load = 0; a8w.en = 1; a8w.up = 0; a8w.step = 4'd3;
    a8s.load = 0; a8s.en = 1; a8s.up = 0; a8s.step = 4'd3;
    tick();
    checks++;
    if (a8w.q !== 8'hFF || a8w.wrap !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap q=%h wrap=%b exp q=ff wrap=1", a8w.q, a8w.wrap);
    end
    checks++;
    if (a8s.q !== 8'h00 || a8s.wrap !== 1'b1) begin
      failures++;
      $display("FAIL down_sat q=%h wrap=%b exp q=00 wrap=1", a8s.q, a8s.wrap);
    end
    a8s.en = 0;
    tick();
    checks++;
    if (a8w.q !== 8'hFC || a8w.wrap !== 1'b0) begin
      failures++;
      $display("FAIL down_plain q=%h wrap=%b exp q=fc wrap=0", a8w.q, a8w.wrap);
    end
    a8w.en = 0;
  endtask

  task automatic test_load_priority;
    a8w.load = 1; a8w.load_val = 8'h40; a8w.en = 1; a8w.up = 1; a8w.step = 4'd1;
    tick();
    checks++;
    if (a8w.q !== 8'h40 || a8w.wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_over_en q=%h wrap=%b exp q=40 wrap=0", a8w.q, a8w.wrap);
    end
    a8w.load = 0; a8w.step = 4'd0;
    tick();
    checks++;
    if (a8w.q !== 8'h40 || a8w.wrap !== 1'b0) begin
      failures++;
      $display("FAIL step0_up q=%h wrap=%b exp q=40 wrap=0", a8w.q, a8w.wrap);
    end
    a8w.up = 0;
    tick();
    checks++;
    if (a8w.q !== 8'h40 || a8w.wrap !== 1'b0) begin
      failures++;
      $display("FAIL step0_down q=%h wrap=%b exp q=40 wrap=0", a8w.q, a8w.wrap);
    end
    a8w.en = 0;
  endtask

  task automatic test_long16;
    int m;
    int nwrap;
    logic exp_wrap;
    m = 0;
    nwrap = 0;
    a16.en = 1; a16.up = 1; a16.step = 4'd15;
    for (int i = 0; i < 4370; i++) begin
      exp_wrap = (m + 15) > 65535;
      m = (m + 15) % 65536;
      tick();
      if (a16.wrap === 1'b1) nwrap++;
      checks++;
      if (a16.q !== 16'(m) || a16.wrap !== exp_wrap) begin
        failures++;
        $display("FAIL long16 edge=%0d q=%h wrap=%b exp q=%h wrap=%b", i, a16.q, a16.wrap, 16'(m), exp_wrap);
      end
    end
    checks++;
    if (nwrap != 1 || a16.q !== 16'd14) begin
      failures++;
      $display("FAIL long16_wrapcount wraps=%0d q=%0d exp wraps=1 q=14", nwrap, a16.q);
    end
    a16.en = 0; a16.load = 1; a16.load_val = 16'hFFF8;
    tick();
    a16.load = 0; a16.en = 1; a16.clr_ovf = 1;
    tick();
    checks++;
    if (a16.q !== 16'h0007 || a16.wrap !== 1'b1 || a16.ovf !== 1'b1) begin
      failures++;
      $display("FAIL clr_vs_wrap q=%h wrap=%b ovf=%b exp q=0007 wrap=1 ovf=1", a16.q, a16.wrap, a16.ovf);
    end
    a16.en = 0;
    tick();
    a16.clr_ovf = 0;
    checks++;
    if (a16.ovf !== 1'b0 || a16.q !== 16'h0007) begin
      failures++;
      $display("FAIL clr_after q=%h ovf=%b exp q=0007 ovf=0", a16.q, a16.ovf);
    end
  endtask

  task automatic test_reset_midcount;
    a8s.en = 1; a8s.up = 1; a8s.step = 4'd7;
    reset_ = 0;
    tick();
    reset_ = 1;
    a8s.en = 0;
    checks++;
    if (a8s.q !== 8'h00 || a8s.ovf !== 1'b0 || a8s.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid q=%h wrap=%b ovf=%b exp q=00 wrap=0 ovf=0", a8s.q, a8s.wrap, a8s.ovf);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_saturate_up();
    test_down();
    test_load_priority();
    test_long16();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
